// File: rtl/qspline_mul_pkg.sv
// Shared types and helpers for the qspline multiplier arbiter: widths,
// the S1 pipeline entry and the round-robin pick function.
package qspline_mul_pkg;

    localparam int OPER_W  = 10;
    localparam int PROD_W  = 20;
    localparam int CNT_W   = 16;
    localparam int MAX_REQ = 8;
    localparam int IDX_W   = 3;

    typedef struct packed {
        logic [OPER_W-1:0] a;
        logic [OPER_W-1:0] b;
        logic [IDX_W-1:0]  id;
    } s1_entry_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] index;
    } rr_pick_t;

    // First set bit of mask at or after ptr, wrapping modulo n (ptr < n).
    function automatic rr_pick_t rr_pick(
        input logic [MAX_REQ-1:0] mask,
        input logic [IDX_W-1:0]   ptr,
        input int                 n
    );
        rr_pick_t     res;
        logic [IDX_W:0] idx;
        res = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            idx = {1'b0, ptr} + 4'(i);
            if (idx >= 4'(n)) begin
                idx = idx - 4'(n);
            end else begin
                idx = idx;
            end
            if ((i < n) && !res.found && mask[idx[IDX_W-1:0]]) begin
                res.found = 1'b1;
                res.index = idx[IDX_W-1:0];
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/qspline_mul_mul_10ns_10ns_20_1_1.sv
// Shared unsigned multiplier; the single-stage variant is purely combinational
// and produces the full-width product.
module qspline_mul_mul_10ns_10ns_20_1_1 #(
    parameter int NUM_STAGE  = 1,
    parameter int din0_WIDTH = 10,
    parameter int din1_WIDTH = 10,
    parameter int dout_WIDTH = 20
) (
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic [dout_WIDTH-1:0] dout
);

    // Only the combinational (single-stage) flavour exists in this datapath.
    if (NUM_STAGE == 1) begin : g_comb
        assign dout = dout_WIDTH'(din0) * dout_WIDTH'(din1);
    end

endmodule

// File: rtl/qspline_mul_arbiter.sv
// Round-robin scheduler sharing one 10x10 multiplier among NUM_REQ requesters;
// two-stage pipeline (operands, product) with a tagged, backpressured response.
module qspline_mul_arbiter
    import qspline_mul_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*OPER_W-1:0] req_a,
    input  logic [NUM_REQ*OPER_W-1:0] req_b,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [PROD_W-1:0]         resp_data,
    output logic [ID_W-1:0]           resp_id,
    output logic [CNT_W-1:0]          op_count,
    output logic                      busy
);

    s1_entry_t          s1_r;
    s1_entry_t          cand_s;
    logic               s1_valid_r;
    logic               s2_valid_r;
    logic [PROD_W-1:0]  s2_data_r;
    logic [PROD_W-1:0]  prod_s;
    logic [IDX_W-1:0]   s2_id_r;
    logic [IDX_W-1:0]   rr_ptr_r;
    logic [CNT_W-1:0]   op_count_r;
    logic [MAX_REQ-1:0] mask_s;
    rr_pick_t           pick_s;
    logic               s1_en_s;
    logic               s2_en_s;
    logic               accept_s;

    // Reset forces s1_en low so nothing is granted during the reset cycle.
    assign s2_en_s  = !s2_valid_r | resp_ready;
    assign s1_en_s  = (!s1_valid_r | s2_en_s) & !ap_rst;
    assign accept_s = pick_s.found & s1_en_s;

    // Widen req_valid to the fixed mask width used by the pick function.
    always_comb begin
        mask_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            mask_s[i] = req_valid[i];
        end
    end

    assign pick_s = rr_pick(mask_s, rr_ptr_r, NUM_REQ);

    // One-hot grant to the winner while S1 can take a new entry.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (accept_s && (pick_s.index == IDX_W'(i))) begin
                req_ready[i] = 1'b1;
            end else begin
                req_ready[i] = 1'b0;
            end
        end
    end

    // Select the winner's operand pair.
    always_comb begin
        cand_s    = '0;
        cand_s.a  = req_a[int'(pick_s.index)*OPER_W +: OPER_W];
        cand_s.b  = req_b[int'(pick_s.index)*OPER_W +: OPER_W];
        cand_s.id = pick_s.index;
    end

    // Round-robin pointer and accept counter.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            rr_ptr_r   <= '0;
            op_count_r <= '0;
        end else if (accept_s) begin
            rr_ptr_r   <= (pick_s.index == IDX_W'(NUM_REQ-1)) ? IDX_W'(0)
                                                             : pick_s.index + IDX_W'(1);
            op_count_r <= op_count_r + 16'd1;
        end
    end

    // S1 operand stage; empties when enabled without a new accept.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            s1_valid_r <= 1'b0;
            s1_r       <= '0;
        end else if (s1_en_s) begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_r <= cand_s;
            end
        end
    end

    qspline_mul_mul_10ns_10ns_20_1_1 #(
        .NUM_STAGE  (1),
        .din0_WIDTH (OPER_W),
        .din1_WIDTH (OPER_W),
        .dout_WIDTH (PROD_W)
    ) u_mul (
        .din0 (s1_r.a),
        .din1 (s1_r.b),
        .dout (prod_s)
    );

    // S2 product stage; holds while the consumer stalls.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            s2_valid_r <= 1'b0;
            s2_data_r  <= '0;
            s2_id_r    <= '0;
        end else if (s2_en_s) begin
            s2_valid_r <= s1_valid_r;
            s2_data_r  <= prod_s;
            s2_id_r    <= s1_r.id;
        end
    end

    assign resp_valid = s2_valid_r;
    assign resp_data  = s2_data_r;
    assign resp_id    = ID_W'(s2_id_r);
    assign op_count   = op_count_r;
    assign busy       = s1_valid_r | s2_valid_r;

endmodule

// File: tb/tb_qspline_mul_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// against a scoreboard model of grants, ordering, latency and the counter.
module tb_qspline_mul_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                   ap_clk;
    logic                   ap_rst;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ*10-1:0]  req_a;
    logic [NUM_REQ*10-1:0]  req_b;
    logic [NUM_REQ-1:0]     req_ready;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [19:0]            resp_data;
    logic [ID_W-1:0]        resp_id;
    logic [15:0]            op_count;
    logic                   busy;

    qspline_mul_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .ap_clk     (ap_clk),
        .ap_rst     (ap_rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .op_count   (op_count),
        .busy       (busy)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    typedef struct {
        int unsigned prod;
        int          id;
        int          edge_no;
    } exp_t;

    exp_t        sb[$];
    int          m_ptr;
    logic [15:0] m_cnt;
    int          edges;
    int          last_win;
    bit          stall_prev;
    logic [19:0] held_data;
    logic [ID_W-1:0] held_id;
    int          n_tests;
    int          n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic [9:0] a, input logic [9:0] b);
        req_a[i*10 +: 10] = a;
        req_b[i*10 +: 10] = b;
    endtask

    // Re-roll requesters that are idle or were just accepted; hold the rest.
    task automatic gen(input int pct);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!req_valid[i] || i == last_win) begin
                if ($urandom_range(99) < pct) begin
                    req_valid[i] = 1'b1;
                    set_req(i, 10'($urandom), 10'($urandom));
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    endtask

    // One clock: check outputs against the model at negedge, then advance.
    task automatic step();
        int w;
        bit found;
        logic [NUM_REQ-1:0] er;
        int unsigned a, b;
        @(negedge ap_clk);
        found = 0;
        w = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int j;
            j = (m_ptr + k) % NUM_REQ;
            if (!found && req_valid[j]) begin
                found = 1;
                w = j;
            end
        end
        er = '0;
        if (found && (sb.size() < 2 || resp_ready)) er[w] = 1'b1;
        chk("req_ready", req_ready, er);
        chk("op_count", op_count, m_cnt);
        chk("resp_valid", resp_valid, (sb.size() > 0 && (edges - sb[0].edge_no) >= 1));
        chk("busy", busy, sb.size() > 0);
        if (stall_prev) begin
            chk("hold_data", resp_data, held_data);
            chk("hold_id", resp_id, held_id);
        end
        stall_prev = resp_valid && !resp_ready;
        held_data  = resp_data;
        held_id    = resp_id;
        if (resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_resp", 32'd1, 32'd0);
            end else begin
                chk("resp_data", resp_data, sb[0].prod);
                chk("resp_id", resp_id, sb[0].id);
                void'(sb.pop_front());
            end
        end
        last_win = -1;
        if (er != '0) begin
            a = req_a[w*10 +: 10];
            b = req_b[w*10 +: 10];
            sb.push_back('{prod: a * b, id: w, edge_no: edges + 1});
            m_ptr = (w + 1) % NUM_REQ;
            m_cnt = m_cnt + 16'd1;
            last_win = w;
        end
        @(posedge ap_clk);
        edges++;
        #1;
    endtask

    task automatic do_reset();
        ap_rst     = 1'b1;
        req_valid  = '1;
        resp_ready = 1'b1;
        @(negedge ap_clk);
        chk("rst_req_ready", req_ready, '0);
        @(posedge ap_clk);
        edges++;
        #1;
        ap_rst    = 1'b0;
        req_valid = '0;
        sb.delete();
        m_ptr      = 0;
        m_cnt      = 16'd0;
        stall_prev = 0;
        last_win   = -1;
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_op_count", op_count, 16'd0);
        chk("rst_resp_data", resp_data, 20'd0);
        chk("rst_resp_id", resp_id, '0);
    endtask

    task automatic drain();
        req_valid  = '0;
        resp_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        chk("drain_empty", sb.size(), 32'd0);
    endtask

    initial begin
        int acc;
        n_tests = 0; n_fail = 0; edges = 0; last_win = -1;
        ap_rst = 1'b1; req_valid = '0; resp_ready = 1'b0;
        req_a = '0; req_b = '0;

        // Single request, full-scale operands, two-cycle latency.
        do_reset();
        resp_ready = 1'b1;
        req_valid  = 4'b0001;
        set_req(0, 10'd1023, 10'd1023);
        step();
        chk("t1_accept", last_win, 32'd0);
        req_valid = '0;
        step();
        chk("t1_resp_data", resp_data, 20'hFF801);
        chk("t1_resp_id", resp_id, 2'd0);
        chk("t1_op_count", op_count, 16'd1);
        chk("t1_resp_valid", resp_valid, 1'b1);
        drain();

        // All requesters valid: strict 0,1,2,3 rotation, one grant per cycle.
        do_reset();
        resp_ready = 1'b1;
        gen(100);
        for (int k = 0; k < 12; k++) begin
            step();
            chk("t2_rr_order", last_win, k % NUM_REQ);
            gen(100);
        end
        drain();

        // Stall: two results buffered, third refused, then ordered drain.
        resp_ready = 1'b0;
        req_valid  = 4'b0100;
        set_req(2, 10'd3, 10'd5);
        acc = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (last_win == 2) acc++;
        end
        chk("t3_stall_accepts", acc, 32'd2);
        chk("t3_stall_data", resp_data, 20'd15);
        chk("t3_stall_ready", req_ready, '0);
        resp_ready = 1'b1;
        step();
        chk("t3_release_accept", last_win, 32'd2);
        for (int k = 0; k < 3; k++) step();
        drain();

        // Pointer at 2 with only req1/req3 valid: 3 wins, then 1.
        do_reset();
        resp_ready = 1'b1;
        req_valid  = 4'b0011;
        set_req(0, 10'd7, 10'd9);
        set_req(1, 10'd11, 10'd13);
        step();
        step();
        chk("t4_setup", last_win, 32'd1);
        req_valid = 4'b1010;
        set_req(3, 10'd100, 10'd200);
        step();
        chk("t4_first", last_win, 32'd3);
        step();
        chk("t4_second", last_win, 32'd1);
        drain();

        // Reset with both stages occupied.
        do_reset();
        resp_ready = 1'b0;
        gen(100);
        for (int k = 0; k < 3; k++) begin
            step();
            gen(100);
        end
        chk("t5_full_busy", busy, 1'b1);
        do_reset();
        resp_ready = 1'b1;
        req_valid  = 4'b0110;
        set_req(1, 10'd21, 10'd2);
        set_req(2, 10'd5, 10'd5);
        step();
        chk("t5_lowest_grant", last_win, 32'd1);
        drain();

        // Randomized traffic with random backpressure.
        for (int k = 0; k < 800; k++) begin
            resp_ready = ($urandom_range(99) < 60);
            gen(50);
            step();
        end
        drain();

        // 65536 accepts wrap the counter back to zero.
        do_reset();
        resp_ready = 1'b1;
        gen(100);
        for (int k = 0; k < 65536; k++) begin
            step();
            gen(100);
        end
        chk("t7_wrap", op_count, 16'd0);
        chk("t7_busy", busy, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
